// File: rtl/pll_clock_sequencer.sv
// Lock-qualified reset sequencer: holds sys_reset until the synchronised PLL lock
// has been stable for SETTLE_CYCLES, then emits per-channel divided clock enables.
//
// state     | meaning
// WAIT_LOCK | reset held, waiting for synchronised lock
// SETTLE    | lock seen, counting consecutive stable cycles
// RUN       | reset released, strobes active
// LOST      | lock dropped in RUN, reset held for HOLD_CYCLES
module pll_clock_sequencer #(
   parameter int                    N_CH          = 4,
   parameter int                    DIV_W         = 16,
   parameter logic [N_CH*DIV_W-1:0] DIVISORS      = {16'd1000, 16'd96, 16'd3, 16'd1},
   parameter int                    SETTLE_CYCLES = 1024,
   parameter int                    HOLD_CYCLES   = 16,
   parameter int                    LOSS_W        = 8
) (
   input  logic              global_clock,
   input  logic              reset,
   input  logic              pll_locked,
   output logic              sys_reset,
   output logic              ready,
   output logic [N_CH-1:0]   strobe,
   output logic [LOSS_W-1:0] lock_loss_count
);

   localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2,
      LOST      = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic                lk_meta, lk;
   logic [SET_W-1:0]    settle_cnt, settle_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic [LOSS_W-1:0]   loss_nxt;
   logic [DIV_W-1:0]    div_cnt [N_CH];
   logic [DIV_W-1:0]    div_nxt [N_CH];
   logic [N_CH-1:0]     strobe_nxt;

   always_comb begin
      state_nxt  = state;
      settle_nxt = '0;
      hold_nxt   = '0;
      loss_nxt   = lock_loss_count;
      unique case (state)
         WAIT_LOCK: begin
            if (lk) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!lk)                        state_nxt = WAIT_LOCK;
            else if (settle_cnt == SET_LAST) state_nxt = RUN;
            else                            settle_nxt = settle_cnt + 1'b1;
         end
         RUN: begin
            if (!lk) begin
               state_nxt = LOST;
               if (lock_loss_count != '1) loss_nxt = lock_loss_count + 1'b1;
            end
         end
         LOST: begin
            if (hold_cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
            else                       hold_nxt  = hold_cnt + 1'b1;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // Strobe registers look at the next state so they drop together with ready.
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      localparam logic [DIV_W-1:0] DIV = DIVISORS[k*DIV_W +: DIV_W];

      always_comb begin
         div_nxt[k]    = '0;
         strobe_nxt[k] = 1'b0;
         if (state_nxt == RUN && DIV != '0) begin
            if (state == RUN && div_cnt[k] != DIV - 1'b1)
               div_nxt[k] = div_cnt[k] + 1'b1;
            strobe_nxt[k] = (div_nxt[k] == DIV - 1'b1);
         end
      end

      always_ff @(posedge global_clock) begin
         if (reset) div_cnt[k] <= '0;
         else       div_cnt[k] <= div_nxt[k];
      end
   end

   always_ff @(posedge global_clock) begin
      if (reset) begin
         lk_meta         <= 1'b0;
         lk              <= 1'b0;
         state           <= WAIT_LOCK;
         settle_cnt      <= '0;
         hold_cnt        <= '0;
         lock_loss_count <= '0;
         sys_reset       <= 1'b1;
         ready           <= 1'b0;
         strobe          <= '0;
      end else begin
         lk_meta         <= pll_locked;
         lk              <= lk_meta;
         state           <= state_nxt;
         settle_cnt      <= settle_nxt;
         hold_cnt        <= hold_nxt;
         lock_loss_count <= loss_nxt;
         sys_reset       <= (state_nxt != RUN);
         ready           <= (state_nxt == RUN);
         strobe          <= strobe_nxt;
      end
   end

endmodule

// File: tb/tb_pll_clock_sequencer.sv
// Directed bench for pll_clock_sequencer: power-up, strobe phasing, settle abort,
// lock loss with hold, loss-counter saturation and reset while running.
module tb_pll_clock_sequencer;

   logic       global_clock = 1'b0;
   logic       reset;
   logic       pll_locked;
   logic       sys_reset;
   logic       ready;
   logic [3:0] strobe;
   logic [1:0] lock_loss_count;

   int n_checks = 0;
   int n_errors = 0;

   pll_clock_sequencer #(
      .N_CH         (4),
      .DIV_W        (16),
      .DIVISORS     ({16'd0, 16'd4, 16'd3, 16'd1}),
      .SETTLE_CYCLES(8),
      .HOLD_CYCLES  (16),
      .LOSS_W       (2)
   ) dut (
      .global_clock   (global_clock),
      .reset          (reset),
      .pll_locked     (pll_locked),
      .sys_reset      (sys_reset),
      .ready          (ready),
      .strobe         (strobe),
      .lock_loss_count(lock_loss_count)
   );

   always #5 global_clock = ~global_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge global_clock);
      #1;
   endtask

   task automatic check_ready(input string tag, input logic r);
      check({tag, "_ready"}, {31'd0, ready}, {31'd0, r});
      check({tag, "_sys_reset"}, {31'd0, sys_reset}, {31'd0, !r});
   endtask

   // Drop lock in RUN, relock right after ready falls, expect ready back on edge 28.
   task automatic loss_cycle(input string tag, input logic [1:0] exp_count);
      pll_locked = 1'b0;
      tick(1);
      check_ready({tag, "_e1"}, 1'b1);
      tick(1);
      check_ready({tag, "_e2"}, 1'b1);
      tick(1);
      check_ready({tag, "_e3"}, 1'b0);
      check({tag, "_strobe_off"}, {28'd0, strobe}, 32'd0);
      check({tag, "_count"}, {30'd0, lock_loss_count}, {30'd0, exp_count});
      pll_locked = 1'b1;
      for (int e = 4; e <= 27; e++) begin
         tick(1);
         check_ready({tag, "_hold"}, 1'b0);
      end
      tick(1);
      check_ready({tag, "_relock"}, 1'b1);
   endtask

   // Expected {ch3,ch2,ch1,ch0} for RUN cycles 1..12 with divisors {0,4,3,1}.
   logic [3:0] stb_exp [12] = '{4'b0001, 4'b0001, 4'b0011, 4'b0101,
                                4'b0001, 4'b0011, 4'b0001, 4'b0101,
                                4'b0011, 4'b0001, 4'b0001, 4'b0111};
   logic [1:0] sat_exp [4]  = '{2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      reset      = 1'b1;
      pll_locked = 1'b0;
      tick(3);
      check_ready("rst", 1'b0);
      check("rst_strobe", {28'd0, strobe}, 32'd0);
      check("rst_count", {30'd0, lock_loss_count}, 32'd0);

      // Power-up with lock high from the first edge after release.
      reset      = 1'b0;
      pll_locked = 1'b1;
      check_ready("post_rst", 1'b0);
      for (int e = 1; e <= 10; e++) begin
         tick(1);
         check_ready("pwr_wait", 1'b0);
         check("pwr_wait_strobe", {28'd0, strobe}, 32'd0);
      end
      tick(1);
      check_ready("pwr_run", 1'b1);
      for (int n = 0; n < 12; n++) begin
         if (n > 0) tick(1);
         check("pwr_strobe", {28'd0, strobe}, {28'd0, stb_exp[n]});
      end

      // Reset for one cycle while strobing.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_ready("midrun_rst", 1'b0);
      check("midrun_rst_strobe", {28'd0, strobe}, 32'd0);
      check("midrun_rst_count", {30'd0, lock_loss_count}, 32'd0);
      tick(10);
      check_ready("midrun_e10", 1'b0);
      tick(1);
      check_ready("midrun_e11", 1'b1);

      // Settle abort: lock low on edges 7 and 8, FSM sees it at edge 9.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(6);
      pll_locked = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      for (int e = 9; e <= 18; e++) begin
         tick(1);
         check_ready("abort_wait", 1'b0);
      end
      check("abort_count", {30'd0, lock_loss_count}, 32'd0);
      tick(1);
      check_ready("abort_run", 1'b1);
      check("abort_count_run", {30'd0, lock_loss_count}, 32'd0);

      tick(5);
      loss_cycle("loss1", 2'd1);
      for (int i = 0; i < 4; i++) begin
         tick(3);
         loss_cycle("sat", sat_exp[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
